// File: rtl/video_io_pkg.sv
// Shared defaults and helpers for the video core I/O adapter.
//   DEF_DIV, DEF_DEB_CYCLES, DEF_RGB_W, DEF_FRAME_W : default parameter values
//   cnt_width()                                     : counter width for divider/debounce
package video_io_pkg;

  localparam int unsigned DEF_DIV        = 2;
  localparam int unsigned DEF_DEB_CYCLES = 16;
  localparam int unsigned DEF_RGB_W      = 3;
  localparam int unsigned DEF_FRAME_W    = 8;

  // Width of a counter that must hold values up to max(div, deb, 2) - 1.
  function automatic int unsigned cnt_width(input int unsigned div, input int unsigned deb);
    int unsigned m;
    m = (div > deb) ? div : deb;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: 2-flop synchronizer, debounce counter, stable level,
// rise detect and a press event held until the core consumes it on ce.
//   clk, reset : board clock, async active-high reset
//   key        : raw asynchronous key input
//   ce         : core clock enable (a pending press clears at the end of a ce cycle)
//   level      : debounced key level
//   press      : pending press event
module key_debounce
  import video_io_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic ce,
  output logic level,
  output logic press
);

  localparam int unsigned   CW       = cnt_width(1, DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          take_c;
  logic          rise_c;

  // The synchronized value has differed long enough to be accepted.
  assign take_c = (sync_q != stable) && (cnt == CNT_LAST);
  assign rise_c = take_c && sync_q;

  // Synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= key;
      sync_q    <= sync_meta;
    end
  end

  // Debounce counter and stable level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q == stable) begin
      cnt <= '0;
    end else if (take_c) begin
      stable <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Press event: a fresh rise beats a same-edge consume; repeated rises merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press <= 1'b0;
    end else if (rise_c) begin
      press <= 1'b1;
    end else if (ce) begin
      press <= 1'b0;
    end
  end

  assign level = stable;

endmodule

// File: rtl/video_core_io_adapter.sv
// Board-side adapter for a video core: clock-enable divider, debounced keys
// with press handshake, ce-sampled video output registers with pin polarity,
// and a frame counter on ce-sampled vsync rising edges.
//   clk, reset                       : board clock, async active-high reset
//   keys -> key_level, key_press     : raw keys to debounced levels / press events
//   ce                               : core clock enable
//   core_hsync, core_vsync, core_rgb : video from the core
//   hsync, vsync, rgb                : video to the board pins
//   frame_cnt                        : completed frame count (wraps)
module video_core_io_adapter
  import video_io_pkg::*;
#(
  parameter int unsigned DIV        = DEF_DIV,
  parameter int unsigned NKEYS      = 4,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned RGB_W      = DEF_RGB_W,
  parameter int unsigned HS_INV     = 0,
  parameter int unsigned VS_INV     = 0,
  parameter int unsigned FRAME_W    = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NKEYS-1:0]   keys,
  output logic               ce,
  output logic [NKEYS-1:0]   key_level,
  output logic [NKEYS-1:0]   key_press,
  input  logic               core_hsync,
  input  logic               core_vsync,
  input  logic [RGB_W-1:0]   core_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned   CW       = cnt_width(DIV, DEB_CYCLES);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          hs_reg;
  logic          vs_reg;

  // Divider: ce is registered so it is high in the cycle after the counter
  // wraps, giving the first ce exactly DIV cycles after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      ce      <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
      ce      <= (div_cnt == DIV_LAST);
    end
  end

  // Per-key debounce and press handshake
  for (genvar i = 0; i < int'(NKEYS); i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key (
      .clk   (clk),
      .reset (reset),
      .key   (keys[i]),
      .ce    (ce),
      .level (key_level[i]),
      .press (key_press[i])
    );
  end

  // Video registers and frame counter; vs_reg doubles as the previous
  // ce-sampled vsync, so pin polarity never reaches the edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_reg    <= 1'b0;
      vs_reg    <= 1'b0;
      rgb       <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      hs_reg <= core_hsync;
      vs_reg <= core_vsync;
      rgb    <= core_rgb;
      if (core_vsync && !vs_reg) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign hsync = hs_reg ^ 1'(HS_INV);
  assign vsync = vs_reg ^ 1'(VS_INV);

endmodule

// File: tb/tb_video_core_io_adapter.sv
module tb_video_core_io_adapter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic [1:0] keys_x;
  logic       key_idle;
  logic       core_hsync, core_vsync;
  logic [2:0] core_rgb;

  // Main instance: DIV=4, DEB=16, HS_INV=1, FRAME_W=2
  logic       ce;
  logic [3:0] key_level, key_press;
  logic       hsync, vsync;
  logic [2:0] rgb;
  logic [1:0] frame_cnt;

  // DIV=3 and DIV=1 divider instances
  logic       ce3, ce1;
  logic [0:0] kl3, kp3, kl1, kp1;
  logic       hs3, vs3, hs1, vs1;
  logic [2:0] rgb3, rgb1;
  logic [7:0] fc3, fc1;

  // DIV=4, DEB=2 instance for the set-beats-clear case
  logic       cex;
  logic [1:0] klx, kpx;
  logic       hsx, vsx;
  logic [2:0] rgbx;
  logic [7:0] fcx;

  int cyc;
  int checks;
  int errors;

  always #5 clk = ~clk;

  video_core_io_adapter #(
    .DIV(4), .NKEYS(4), .DEB_CYCLES(16), .RGB_W(3), .HS_INV(1), .VS_INV(0), .FRAME_W(2)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .ce(ce), .key_level(key_level),
    .key_press(key_press), .core_hsync(core_hsync), .core_vsync(core_vsync),
    .core_rgb(core_rgb), .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_cnt(frame_cnt)
  );

  video_core_io_adapter #(.DIV(3), .NKEYS(1)) dut3 (
    .clk(clk), .reset(reset), .keys(key_idle), .ce(ce3), .key_level(kl3),
    .key_press(kp3), .core_hsync(core_hsync), .core_vsync(core_vsync),
    .core_rgb(core_rgb), .hsync(hs3), .vsync(vs3), .rgb(rgb3), .frame_cnt(fc3)
  );

  video_core_io_adapter #(.DIV(1), .NKEYS(1)) dut1 (
    .clk(clk), .reset(reset), .keys(key_idle), .ce(ce1), .key_level(kl1),
    .key_press(kp1), .core_hsync(core_hsync), .core_vsync(core_vsync),
    .core_rgb(core_rgb), .hsync(hs1), .vsync(vs1), .rgb(rgb1), .frame_cnt(fc1)
  );

  video_core_io_adapter #(.DIV(4), .NKEYS(2), .DEB_CYCLES(2)) dutx (
    .clk(clk), .reset(reset), .keys(keys_x), .ce(cex), .key_level(klx),
    .key_press(kpx), .core_hsync(core_hsync), .core_vsync(core_vsync),
    .core_rgb(core_rgb), .hsync(hsx), .vsync(vsx), .rgb(rgbx), .frame_cnt(fcx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_n(3);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce got=%b exp=0", ce); end
    checks++; if (key_level !== 4'h0) begin errors++; $display("FAIL rst_key_level got=%h exp=0", key_level); end
    checks++; if (key_press !== 4'h0) begin errors++; $display("FAIL rst_key_press got=%h exp=0", key_press); end
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rst_rgb got=%b exp=000", rgb); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL rst_vsync got=%b exp=0", vsync); end
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL rst_frame got=%0d exp=0", frame_cnt); end
    checks++; if (ce3 !== 1'b0 || ce1 !== 1'b0) begin errors++; $display("FAIL rst_ce_div got=%b%b exp=00", ce3, ce1); end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_divider();
    logic e3, e4;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e3 = (cyc % 3 == 0);
      e4 = (cyc % 4 == 0);
      checks++; if (ce3 !== e3) begin errors++; $display("FAIL div3_ce cyc=%0d got=%b exp=%b", cyc, ce3, e3); end
      checks++; if (ce1 !== 1'b1) begin errors++; $display("FAIL div1_ce cyc=%0d got=%b exp=1", cyc, ce1); end
      checks++; if (ce !== e4) begin errors++; $display("FAIL div4_ce cyc=%0d got=%b exp=%b", cyc, ce, e4); end
    end
  endtask

  task automatic test_debounce();
    keys[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 11) keys[0] = 1'b0;
      tick();
      checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL glitch_level n=%0d got=%b exp=0", n, key_level[0]); end
    end
    keys[0] = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      tick();
      checks++;
      if (key_level[0] !== (n == 18)) begin
        errors++; $display("FAIL held_level n=%0d got=%b exp=%b", n, key_level[0], (n == 18));
      end
    end
    checks++; if (key_press[0] !== 1'b1) begin errors++; $display("FAIL held_press got=%b exp=1", key_press[0]); end
  endtask

  task automatic test_press();
    int r, m;
    logic e;
    keys[1] = 1'b1;
    r = cyc + 18;
    m = r + ((4 - (r % 4)) % 4);
    while (cyc < m + 2) begin
      tick();
      if (cyc >= r - 1) begin
        e = (cyc >= r) && (cyc <= m);
        checks++; if (key_press[1] !== e) begin errors++; $display("FAIL press_hs cyc=%0d got=%b exp=%b", cyc, key_press[1], e); end
      end
    end
    keys[1] = 1'b0;
    tick_n(30);
    checks++; if (key_press[1] !== 1'b0) begin errors++; $display("FAIL press_after_release got=%b exp=0", key_press[1]); end
  endtask

  task automatic test_set_wins();
    while (cyc % 4 != 1) tick();
    keys_x[1] = 1'b1;
    tick_n(2);
    keys_x[1] = 1'b0;
    tick_n(2);
    checks++; if (kpx[1] !== 1'b1) begin errors++; $display("FAIL setwin_first got=%b exp=1", kpx[1]); end
    keys_x[1] = 1'b1;
    tick_n(4);
    checks++; if (kpx[1] !== 1'b1) begin errors++; $display("FAIL setwin_coincide got=%b exp=1", kpx[1]); end
    tick_n(3);
    checks++; if (kpx[1] !== 1'b1) begin errors++; $display("FAIL setwin_hold got=%b exp=1", kpx[1]); end
    tick();
    checks++; if (kpx[1] !== 1'b0) begin errors++; $display("FAIL setwin_clear got=%b exp=0", kpx[1]); end
  endtask

  task automatic test_video();
    while (cyc % 4 != 0) tick();
    core_rgb   = 3'b101;
    core_hsync = 1'b1;
    tick();
    checks++; if (rgb !== 3'b101) begin errors++; $display("FAIL vid_rgb got=%b exp=101", rgb); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL vid_hsync got=%b exp=0", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL vid_vsync got=%b exp=0", vsync); end
    core_rgb   = 3'b010;
    core_hsync = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (rgb !== 3'b101 || hsync !== 1'b0) begin errors++; $display("FAIL vid_hold n=%0d got=%b/%b exp=101/0", n, rgb, hsync); end
    end
    tick();
    checks++; if (rgb !== 3'b010 || hsync !== 1'b1) begin errors++; $display("FAIL vid_next got=%b/%b exp=010/1", rgb, hsync); end
  endtask

  task automatic vs_pulse(input int phase);
    while (cyc % 4 != phase) tick();
    core_vsync = 1'b1;
    tick_n(2);
    core_vsync = 1'b0;
    tick_n(6);
  endtask

  task automatic test_frame();
    logic [1:0] exp_seq [5];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
    for (int p = 0; p < 5; p++) begin
      vs_pulse(3);
      checks++; if (frame_cnt !== exp_seq[p]) begin errors++; $display("FAIL frame_pulse p=%0d got=%0d exp=%0d", p, frame_cnt, exp_seq[p]); end
    end
    vs_pulse(1);
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL frame_noce got=%0d exp=1", frame_cnt); end
    vs_pulse(3);
    checks++; if (frame_cnt !== 2'd2) begin errors++; $display("FAIL frame_two got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    keys[2] = 1'b1;
    tick_n(18);
    checks++; if (key_press[2] !== 1'b1) begin errors++; $display("FAIL mid_pre_press got=%b exp=1", key_press[2]); end
    reset = 1'b1;
    keys  = 4'h0;
    #1;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL mid_ce got=%b exp=0", ce); end
    checks++; if (key_level !== 4'h0) begin errors++; $display("FAIL mid_key_level got=%h exp=0", key_level); end
    checks++; if (key_press !== 4'h0) begin errors++; $display("FAIL mid_key_press got=%h exp=0", key_press); end
    checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL mid_rgb got=%b exp=000", rgb); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b0) begin errors++; $display("FAIL mid_sync got=%b%b exp=10", hsync, vsync); end
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL mid_frame got=%0d exp=0", frame_cnt); end
    tick_n(3);
    reset = 1'b0;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      checks++; if (key_press !== 4'h0) begin errors++; $display("FAIL mid_post_press cyc=%0d got=%h exp=0", cyc, key_press); end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset      = 1'b1;
    keys       = 4'h0;
    keys_x     = 2'b00;
    key_idle   = 1'b0;
    core_hsync = 1'b0;
    core_vsync = 1'b0;
    core_rgb   = 3'd0;
    test_reset();
    test_divider();
    test_debounce();
    test_press();
    test_set_wins();
    test_video();
    test_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
